// File: rtl/fetch_align_buffer_if.sv
// Fetch-side bus bundle: memory request/response plus the aligned
// instruction stream handed to the IF/ID register.
interface fetch_align_buffer_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_compressed;
  logic        out_ready;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data,
    output out_valid, out_instr, out_pc, out_compressed,
    input  out_ready
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data,
    input  out_valid, out_instr, out_pc, out_compressed,
    output out_ready
  );
endinterface

// File: rtl/fetch_align_buffer.sv
// RV32IC fetch aligner: word fetches into a 3-halfword buffer,
// one aligned 16/32-bit instruction with its PC per handshake.
module fetch_align_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [31:0]          flush_pc,
  fetch_align_buffer_if.master bus
);

  logic [2:0][15:0] hw_q, hw_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic        outstanding_q, outstanding_d;
  logic        discard_q, discard_d;
  logic        drop_low_q, drop_low_d;

  logic        compressed;
  logic        out_valid;
  logic        take;
  logic        req_valid;
  logic        req_fire;
  logic        rsp_fire;
  logic [1:0]  used, keep, added;
  logic [47:0] keep_mask, shifted, ins;

  assign compressed = hw_q[0][1:0] != 2'b11;
  assign out_valid  = !flush &&
    (cnt_q >= 2'd2 || (cnt_q == 2'd1 && compressed));
  assign take       = out_valid && bus.out_ready;
  assign req_valid  = rst && !flush && !outstanding_q &&
    cnt_q <= 2'd1;
  assign req_fire   = req_valid && bus.req_ready;
  assign rsp_fire   = bus.rsp_valid && outstanding_q && !flush;

  assign bus.req_valid      = req_valid;
  assign bus.req_addr       = fetch_addr_q;
  assign bus.out_valid      = out_valid;
  assign bus.out_instr      = compressed ? {16'h0, hw_q[0]}
                                         : {hw_q[1], hw_q[0]};
  assign bus.out_pc         = buf_pc_q;
  assign bus.out_compressed = compressed && cnt_q != 2'd0;

  always_comb begin
    used  = take ? (compressed ? 2'd1 : 2'd2) : 2'd0;
    keep  = cnt_q - used;
    ins   = '0;
    added = 2'd0;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    drop_low_d    = drop_low_q;
    fetch_addr_d  = fetch_addr_q;
    buf_pc_d      = buf_pc_q +
      (take ? (compressed ? 32'd2 : 32'd4) : 32'd0);

    if (req_fire) begin
      outstanding_d = 1'b1;
      fetch_addr_d  = fetch_addr_q + 32'd4;
    end

    if (rsp_fire) begin
      outstanding_d = 1'b0;
      if (discard_q) begin
        discard_d = 1'b0;
      end else if (drop_low_q) begin
        ins        = {32'h0, bus.rsp_data[31:16]};
        added      = 2'd1;
        drop_low_d = 1'b0;
      end else begin
        ins   = {16'h0, bus.rsp_data};
        added = 2'd2;
      end
    end

    // survivors slide down to hw0, new halfwords land right above them
    keep_mask = ~({48{1'b1}} << {keep, 4'b0});
    shifted   = (hw_q >> {used, 4'b0}) & keep_mask;
    hw_d      = shifted | (ins << {keep, 4'b0});
    cnt_d     = keep + added;

    if (flush) begin
      cnt_d        = 2'd0;
      hw_d         = hw_q;
      buf_pc_d     = flush_pc & ~32'd1;
      fetch_addr_d = flush_pc & ~32'd3;
      drop_low_d   = flush_pc[1];
      if (outstanding_q) begin
        if (bus.rsp_valid) begin
          outstanding_d = 1'b0;
          discard_d     = 1'b0;
        end else begin
          discard_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hw_q          <= '0;
      cnt_q         <= 2'd0;
      buf_pc_q      <= RESET_PC;
      fetch_addr_q  <= {RESET_PC[31:2], 2'b00};
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      drop_low_q    <= RESET_PC[1];
    end else begin
      hw_q          <= hw_d;
      cnt_q         <= cnt_d;
      buf_pc_q      <= buf_pc_d;
      fetch_addr_q  <= fetch_addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      drop_low_q    <= drop_low_d;
    end
  end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Directed bench for fetch_align_buffer: hand-computed
// instruction/PC streams, flush, back-pressure, reset and wrap.
module tb_fetch_align_buffer;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] flush_pc;
  int          n_tests;
  int          n_fail;

  fetch_align_buffer_if bus ();

  fetch_align_buffer #(.RESET_PC(32'h0)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .flush_pc (flush_pc),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic serve(input logic [31:0] addr,
                       input logic [31:0] data);
    int k;
    k = 0;
    while (!bus.req_valid && k < 20) begin
      step();
      k++;
    end
    chk("req_valid", {31'h0, bus.req_valid}, 32'd1);
    chk("req_addr", bus.req_addr, addr);
    bus.req_ready = 1'b1;
    step();
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b1;
    bus.rsp_data  = data;
    step();
    bus.rsp_valid = 1'b0;
  endtask

  task automatic take(input logic [31:0] instr,
                      input logic [31:0] pc,
                      input logic        c);
    int k;
    k = 0;
    while (!bus.out_valid && k < 20) begin
      step();
      k++;
    end
    chk("out_valid", {31'h0, bus.out_valid}, 32'd1);
    chk("out_instr", bus.out_instr, instr);
    chk("out_pc", bus.out_pc, pc);
    chk("out_compressed", {31'h0, bus.out_compressed}, {31'h0, c});
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b0;
    flush         = 1'b0;
    flush_pc      = 32'h0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = 32'h0;
    bus.out_ready = 1'b0;

    // reset state
    step();
    step();
    chk("rst_req_valid", {31'h0, bus.req_valid}, 32'd0);
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'h0);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_out_c", {31'h0, bus.out_compressed}, 32'd0);
    rst = 1'b1;

    // single 32-bit instruction, latency one cycle after response
    serve(32'h0, 32'h00A0_0093);
    chk("lat_out_valid", {31'h0, bus.out_valid}, 32'd1);
    take(32'h00A0_0093, 32'h0, 1'b0);

    // two compressed instructions in one word
    do_reset();
    serve(32'h0, 32'h4585_4501);
    take(32'h0000_4501, 32'h0, 1'b1);
    take(32'h0000_4585, 32'h2, 1'b1);
    serve(32'h4, 32'h0000_0000);
    take(32'h0000_0000, 32'h4, 1'b1);

    // straddling 32-bit instruction held until second word
    do_reset();
    serve(32'h0, 32'h0093_4501);
    take(32'h0000_4501, 32'h0, 1'b1);
    chk("straddle_hold", {31'h0, bus.out_valid}, 32'd0);
    serve(32'h4, 32'h0000_00A0);
    take(32'h00A0_0093, 32'h2, 1'b0);

    // flush with fetch outstanding: stale response dropped
    do_reset();
    bus.req_ready = 1'b1;
    step();
    bus.req_ready = 1'b0;
    flush    = 1'b1;
    flush_pc = 32'h0000_0103;
    #1;
    chk("flush_out_valid", {31'h0, bus.out_valid}, 32'd0);
    step();
    flush = 1'b0;
    chk("flush_req_blocked", {31'h0, bus.req_valid}, 32'd0);
    bus.rsp_valid = 1'b1;
    bus.rsp_data  = 32'hDEAD_BEEF;
    step();
    bus.rsp_valid = 1'b0;
    chk("stale_dropped", {31'h0, bus.out_valid}, 32'd0);
    serve(32'h100, 32'h1234_0001);
    take(32'h0000_1234, 32'h102, 1'b1);

    // back-pressure with a full buffer
    do_reset();
    serve(32'h0, 32'h4585_4501);
    take(32'h0000_4501, 32'h0, 1'b1);
    serve(32'h4, 32'h00A0_0093);
    for (int i = 0; i < 10; i++) begin
      chk("bp_req_valid", {31'h0, bus.req_valid}, 32'd0);
      chk("bp_out_instr", bus.out_instr, 32'h0000_4585);
      chk("bp_out_pc", bus.out_pc, 32'h2);
      step();
    end
    take(32'h0000_4585, 32'h2, 1'b1);
    take(32'h00A0_0093, 32'h4, 1'b0);

    // reset mid-stream
    do_reset();
    serve(32'h0, 32'h4585_4501);
    chk("pre_rst_valid", {31'h0, bus.out_valid}, 32'd1);
    rst = 1'b0;
    step();
    chk("mid_rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    chk("mid_rst_req_valid", {31'h0, bus.req_valid}, 32'd0);
    chk("mid_rst_out_pc", bus.out_pc, 32'h0);
    step();
    rst = 1'b1;
    #1;
    chk("post_rst_req_valid", {31'h0, bus.req_valid}, 32'd1);
    chk("post_rst_req_addr", bus.req_addr, 32'h0);

    // pending request withdrawn by flush; straddle across address wrap
    flush    = 1'b1;
    flush_pc = 32'hFFFF_FFFE;
    #1;
    chk("withdraw_req", {31'h0, bus.req_valid}, 32'd0);
    step();
    flush = 1'b0;
    serve(32'hFFFF_FFFC, 32'h0093_0000);
    chk("wrap_hold", {31'h0, bus.out_valid}, 32'd0);
    serve(32'h0, 32'h0000_00A0);
    take(32'h00A0_0093, 32'hFFFF_FFFE, 1'b0);
    take(32'h0000_0000, 32'h2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
